// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: write-back arbiter bus bundle (ALU result, long-latency
// result handshake, register-file write port, scoreboard query).
interface wb_arbiter_if #(parameter int W = 32);
  logic         alu_valid;
  logic [4:0]   alu_rd;
  logic [W-1:0] alu_data;
  logic         lu_valid;
  logic         lu_ready;
  logic [4:0]   lu_rd;
  logic [W-1:0] lu_data;
  logic         regwrite;
  logic [4:0]   wrreg;
  logic [W-1:0] wrdata;
  logic         full;
  logic         busy;
  logic         issue_valid;
  logic [4:0]   issue_rd;
  logic [4:0]   q1;
  logic [4:0]   q2;
  logic         stall;

  // Producer / register-file side
  modport master (
    output alu_valid, alu_rd, alu_data, lu_valid, lu_rd, lu_data,
           issue_valid, issue_rd, q1, q2,
    input  lu_ready, regwrite, wrreg, wrdata, full, busy, stall
  );

  // Arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_data, lu_valid, lu_rd, lu_data,
           issue_valid, issue_rd, q1, q2,
    output lu_ready, regwrite, wrreg, wrdata, full, busy, stall
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU results (priority) with FIFO-buffered long-latency
// results onto one registered register-file write port.
// Optional feature macro: WB_SCOREBOARD_EN (pending-register scoreboard
// driving stall); when undefined stall is tied low.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_arbiter_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0]   rd;
    logic [W-1:0] data;
  } wb_ent_t;

  wb_ent_t      mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic         full, empty, push, pop, alu_sel;
  logic         regwrite_q, regwrite_d;
  logic [4:0]   wrreg_q, wrreg_d;
  logic [W-1:0] wrdata_q, wrdata_d;
  wb_ent_t      head;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign head  = mem_q[rptr_q[AW-1:0]];

  assign bus.lu_ready = !full;
  assign bus.full     = full;
  assign bus.busy     = !empty;
  assign bus.regwrite = regwrite_q;
  assign bus.wrreg    = wrreg_q;
  assign bus.wrdata   = wrdata_q;

  // Selection: ALU to a real register wins; otherwise pop the head. Emptiness
  // is from the current pointers, so an entry pushed this edge is not popped.
  always_comb begin
    alu_sel    = bus.alu_valid && (bus.alu_rd != 5'd0);
    pop        = !alu_sel && !empty;
    push       = bus.lu_valid && !full && (bus.lu_rd != 5'd0);
    regwrite_d = alu_sel || pop;
    wrreg_d    = wrreg_q;
    wrdata_d   = wrdata_q;
    if (alu_sel) begin
      wrreg_d  = bus.alu_rd;
      wrdata_d = bus.alu_data;
    end else if (pop) begin
      wrreg_d  = head.rd;
      wrdata_d = head.data;
    end
    wptr_d = wptr_q + {{AW{1'b0}}, push};
    rptr_d = rptr_q + {{AW{1'b0}}, pop};
  end

  // Pointer and write-port registers; reset kills queued entries and any write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      regwrite_q <= 1'b0;
      wrreg_q    <= 5'd0;
      wrdata_q   <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      regwrite_q <= regwrite_d;
      wrreg_q    <= wrreg_d;
      wrdata_q   <= wrdata_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= '{rd: bus.lu_rd, data: bus.lu_data};
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:0] pend_q, pend_d;

  // Pop clears its rd; a same-cycle issue to that rd re-sets it (set wins).
  always_comb begin
    pend_d = pend_q;
    if (pop) pend_d[head.rd] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != 5'd0)) pend_d[bus.issue_rd] = 1'b1;
  end

  // Pending vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign bus.stall = pend_q[bus.q1] | pend_q[bus.q2];
`else
  logic unused_sb;
  assign unused_sb = &{1'b0, bus.issue_valid, bus.issue_rd, bus.q1, bus.q2};
  assign bus.stall = 1'b0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed + random stimulus, queue-based reference model,
// per-cycle compare on the falling edge.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int W     = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if #(.W(W)) bus ();
  wb_arbiter #(.DEPTH(DEPTH), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [4:0]   mq_rd [$];
  logic [W-1:0] mq_d  [$];
  bit           exp_rw;
  logic [4:0]   exp_rd;
  logic [W-1:0] exp_d;
  bit   [31:0]  pend;
  int           m_n;

  // Write port = ALU if it targets a real register, else oldest queued
  // result (counted before this edge's push), else nothing.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq_rd.delete(); mq_d.delete();
      exp_rw = 0; exp_rd = 5'd0; exp_d = '0; pend = '0;
    end else begin
      m_n = mq_rd.size();
      if (bus.alu_valid && bus.alu_rd != 5'd0) begin
        exp_rw = 1; exp_rd = bus.alu_rd; exp_d = bus.alu_data;
      end else if (m_n > 0) begin
        exp_rw = 1; exp_rd = mq_rd.pop_front(); exp_d = mq_d.pop_front();
        pend[exp_rd] = 1'b0;
      end else begin
        exp_rw = 0;
      end
      if (bus.lu_valid && m_n < DEPTH && bus.lu_rd != 5'd0) begin
        mq_rd.push_back(bus.lu_rd); mq_d.push_back(bus.lu_data);
      end
      if (bus.issue_valid && bus.issue_rd != 5'd0) pend[bus.issue_rd] = 1'b1;
    end
  end

  function automatic bit exp_stall();
`ifdef WB_SCOREBOARD_EN
    return pend[bus.q1] | pend[bus.q2];
`else
    return 1'b0;
`endif
  endfunction

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    chk("regwrite", 64'(bus.regwrite), 64'(exp_rw));
    chk("wrreg",    64'(bus.wrreg),    64'(exp_rd));
    chk("wrdata",   64'(bus.wrdata),   64'(exp_d));
    chk("lu_ready", 64'(bus.lu_ready), 64'(mq_rd.size() < DEPTH));
    chk("full",     64'(bus.full),     64'(mq_rd.size() == DEPTH));
    chk("busy",     64'(bus.busy),     64'(mq_rd.size() != 0));
    chk("stall",    64'(bus.stall),    64'(exp_stall()));
  end

  // ---------------- stimulus helpers ----------------
  logic [4:0]   log_rd [$];
  logic [W-1:0] log_d  [$];

  task automatic idle();
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = '0;
    bus.lu_valid = 0; bus.lu_rd = 0; bus.lu_data = '0;
    bus.issue_valid = 0; bus.issue_rd = 0; bus.q1 = 0; bus.q2 = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (bus.regwrite) begin log_rd.push_back(bus.wrreg); log_d.push_back(bus.wrdata); end
  endtask

  task automatic alu(input logic [4:0] rd, input logic [W-1:0] d);
    bus.alu_valid = 1; bus.alu_rd = rd; bus.alu_data = d;
  endtask

  task automatic lu(input logic [4:0] rd, input logic [W-1:0] d);
    bus.lu_valid = 1; bus.lu_rd = rd; bus.lu_data = d;
  endtask

  initial begin
    idle();
    // Reset state
    #12;
    chk("rst_regwrite", 64'(bus.regwrite), 64'd0);
    chk("rst_wrreg",    64'(bus.wrreg),    64'd0);
    chk("rst_wrdata",   64'(bus.wrdata),   64'd0);
    chk("rst_lu_ready", 64'(bus.lu_ready), 64'd1);
    chk("rst_busy",     64'(bus.busy),     64'd0);
    chk("rst_stall",    64'(bus.stall),    64'd0);
    @(posedge clk); #2; rst_n = 1'b1;

    // ALU path
    alu(5'd5, 32'h12345678); tick();
    chk("alu_rw",   64'(bus.regwrite), 64'd1);
    chk("alu_rd",   64'(bus.wrreg),    64'd5);
    chk("alu_data", 64'(bus.wrdata),   64'h12345678);
    idle(); tick();
    chk("alu_idle_rw", 64'(bus.regwrite), 64'd0);
    chk("alu_hold_rd", 64'(bus.wrreg),    64'd5);

    // Priority and fill: ALU starves the FIFO until it fills
    log_rd.delete(); log_d.delete();
    for (int i = 0; i < 6; i++) begin
      idle();
      alu(5'(i + 1), W'(32'h100 + i));
      if (i < 4) lu(5'(8 + i), W'(32'hA0 + i));
      tick();
      if (i == 3) begin
        chk("fill_full",     64'(bus.full),     64'd1);
        chk("fill_lu_ready", 64'(bus.lu_ready), 64'd0);
      end
    end
    idle();
    for (int c = 0; c < 10 && bus.busy; c++) tick();
    chk("fill_busy_end", 64'(bus.busy), 64'd0);
    chk("fill_nwrites",  64'(log_rd.size()), 64'd10);
    for (int k = 0; k < 10 && k < log_rd.size(); k++) begin
      chk("fill_order_rd", 64'(log_rd[k]), (k < 6) ? 64'(k + 1) : 64'(k + 2));
      chk("fill_order_d",  64'(log_d[k]),  (k < 6) ? 64'(32'h100 + k) : 64'(32'hA0 + k - 6));
    end

    // Register zero
    idle(); lu(5'd0, 32'hBAD); tick();
    chk("r0_lu_busy", 64'(bus.busy),     64'd0);
    chk("r0_lu_rw",   64'(bus.regwrite), 64'd0);
    idle(); lu(5'd7, 32'h77); tick();
    idle(); alu(5'd0, 32'hDEAD); tick();
    chk("r0_alu_rw",   64'(bus.regwrite), 64'd1);
    chk("r0_alu_rd",   64'(bus.wrreg),    64'd7);
    chk("r0_alu_data", 64'(bus.wrdata),   64'h77);
    idle(); tick();

`ifdef WB_SCOREBOARD_EN
    // Scoreboard set / clear / set-wins
    bus.issue_valid = 1; bus.issue_rd = 9; tick();
    idle(); bus.q1 = 9; #1;
    chk("sb_set", 64'(bus.stall), 64'd1);
    lu(5'd9, 32'h99); tick();
    bus.lu_valid = 0; tick();
    chk("sb_pop_rd",  64'(bus.wrreg), 64'd9);
    chk("sb_cleared", 64'(bus.stall), 64'd0);
    lu(5'd9, 32'h98); tick();
    bus.lu_valid = 0; bus.issue_valid = 1; bus.issue_rd = 9; tick();
    chk("sb_sw_rd",   64'(bus.wrreg), 64'd9);
    chk("sb_setwins", 64'(bus.stall), 64'd1);
    idle(); tick();
`endif

    // Wrap-around with simultaneous push+pop
    log_rd.delete(); log_d.delete();
    for (int k = 0; k < 10; k++) begin
      idle(); lu(5'd20, W'(32'hC0 + k)); tick();
      chk("wrap_nofull", 64'(bus.full), 64'd0);
    end
    idle(); tick(); tick();
    chk("wrap_n", 64'(log_d.size()), 64'd10);
    for (int k = 0; k < 10 && k < log_d.size(); k++)
      chk("wrap_order", 64'(log_d[k]), 64'(32'hC0 + k));

    // Random: heavy ALU phase (fills/starves) then light phase (drains)
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 300; c++) begin
        bus.alu_valid   = ($urandom_range(0, 99) < (ph == 0 ? 85 : 30));
        bus.alu_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.alu_data    = W'($urandom());
        bus.lu_valid    = ($urandom_range(0, 1) == 1);
        bus.lu_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.lu_data     = W'($urandom());
        bus.issue_valid = ($urandom_range(0, 99) < 30);
        bus.issue_rd    = 5'($urandom_range(0, 31));
        bus.q1          = 5'($urandom_range(0, 31));
        bus.q2          = 5'($urandom_range(0, 31));
        tick();
      end
    end

    // Reset mid-operation with two entries queued behind the ALU
    idle(); tick(); tick(); tick(); tick(); tick();
    alu(5'd1, 32'h11); lu(5'd12, 32'hC12); tick();
    alu(5'd2, 32'h22); lu(5'd13, 32'hC13); tick();
    chk("mr_pre_rw",   64'(bus.regwrite), 64'd1);
    chk("mr_pre_busy", 64'(bus.busy),     64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_rw",       64'(bus.regwrite), 64'd0);
    chk("mr_busy",     64'(bus.busy),     64'd0);
    chk("mr_lu_ready", 64'(bus.lu_ready), 64'd1);
    idle();
    @(posedge clk); #2; rst_n = 1'b1;
    log_rd.delete(); log_d.delete();
    for (int c = 0; c < 4; c++) tick();
    chk("mr_no_stale", 64'(log_rd.size()), 64'd0);

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
